// File: rtl/uart_pkg.sv
// Shared UART definitions: line-state enum and fixed framing constants.
// Imported by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int unsigned DATA_BITS  = 8;
    localparam logic        START_BIT  = 1'b0;
    localparam logic        STOP_BIT   = 1'b1;
    localparam logic        IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with registered full/empty flags and first-word-fall-through output.
// Pointers wrap naturally because DEPTH is a power of two.
module byte_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int unsigned    AW     = $clog2(DEPTH);
    localparam logic [AW:0]    L_FULL = (AW + 1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_full;
    logic          r_empty;

    logic          w_do_push;
    logic          w_do_pop;
    logic [AW:0]   w_count_next;

    // A push is refused while the registered full flag is set, even if a pop frees a slot.
    assign w_do_push = push && !r_full;
    assign w_do_pop  = pop && !r_empty;

    always_comb begin
        w_count_next = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (w_do_pop && !w_do_push) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == L_FULL);
            r_empty <= (w_count_next == '0);
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = r_full;
    assign empty = r_empty;

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit stage: buffers bytes in a FIFO and serialises them as 8N1 frames.
// The line output is registered from next-state values so it tracks the FSM without lag.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       serial_connection,
    output logic       busy
);

    localparam int unsigned BW          = $clog2(CLOCKS_PER_BIT);
    localparam logic [BW-1:0] L_BAUD_LAST = BW'(CLOCKS_PER_BIT - 1);
    localparam logic [2:0]    L_BIT_LAST  = 3'(DATA_BITS - 1);

    uart_state_t   r_state;
    uart_state_t   w_state_next;
    logic [BW-1:0] r_baud;
    logic [BW-1:0] w_baud_next;
    logic [2:0]    r_bit_idx;
    logic [2:0]    w_bit_idx_next;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_next;
    logic          r_serial;
    logic          w_serial_next;

    logic          w_push;
    logic          w_pop;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [7:0]    w_fifo_dout;
    logic          w_baud_done;

    assign data_ready = !w_fifo_full && !reset;
    assign w_push     = data_valid && data_ready;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (data_in),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    assign w_baud_done = (r_baud == L_BAUD_LAST);

    always_comb begin
        w_state_next   = r_state;
        w_baud_next    = r_baud + 1'b1;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_pop          = 1'b0;

        case (r_state)
            IDLE: begin
                w_baud_next = '0;
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_fifo_dout;
                    w_state_next = START;
                end
            end
            START: begin
                if (w_baud_done) begin
                    w_baud_next    = '0;
                    w_bit_idx_next = '0;
                    w_state_next   = DATA;
                end
            end
            DATA: begin
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_shift_next = r_shift >> 1;
                    if (r_bit_idx == L_BIT_LAST) begin
                        w_state_next = STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 1'b1;
                    end
                end
            end
            STOP: begin
                // Popping on the last stop cycle chains the next start bit with no idle gap.
                if (w_baud_done) begin
                    w_baud_next = '0;
                    if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_fifo_dout;
                        w_state_next = START;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_baud_next  = '0;
                w_state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        w_serial_next = IDLE_LEVEL;
        case (w_state_next)
            IDLE:    w_serial_next = IDLE_LEVEL;
            START:   w_serial_next = START_BIT;
            DATA:    w_serial_next = w_shift_next[0];
            STOP:    w_serial_next = STOP_BIT;
            default: w_serial_next = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_serial  <= IDLE_LEVEL;
        end else begin
            r_state   <= w_state_next;
            r_baud    <= w_baud_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_serial  <= w_serial_next;
        end
    end

    assign serial_connection = r_serial;
    assign busy              = (r_state != IDLE) || !w_fifo_empty;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: directed frame/timing cases plus randomized
// traffic decoded from the line by an independent frame sampler.
module tb_uart_transmitter;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FRAME = 10 * CPB;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = '0;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic       serial_connection;
    logic       busy;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         nsteps  = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    logic       mon_s [FRAME];
    int         mon_n = 0;
    bit         mon_active = 1'b0;
    int         mon_werr;
    logic [7:0] mon_byte;

    uart_transmitter #(
        .CLOCKS_PER_BIT (CPB),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .data_in           (data_in),
        .data_valid        (data_valid),
        .data_ready        (data_ready),
        .serial_connection (serial_connection),
        .busy              (busy)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected line level for bit period k (0 = start, 1..8 = data LSB first, 9 = stop).
    function automatic logic frame_bit(input logic [7:0] b, input int unsigned k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    // One clock cycle: drive just after the rising edge, return at the falling edge.
    task automatic step(input logic r, input logic v, input logic [7:0] d);
        @(posedge clock);
        #1;
        reset      = r;
        data_valid = v;
        data_in    = d;
        nsteps++;
        @(negedge clock);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy || rx_q.size() < tx_q.size()) && n < 20000) begin
            step(1'b0, 1'b0, 8'h00);
            n++;
        end
        check_eq({tag, "_idle_timeout"}, 32'(n < 20000), 32'd1);
    endtask

    task automatic compare_stream(input string tag);
        int m;
        check_eq({tag, "_count"}, 32'(rx_q.size()), 32'(tx_q.size()));
        m = (rx_q.size() < tx_q.size()) ? rx_q.size() : tx_q.size();
        for (int i = 0; i < m; i++) begin
            check_eq({tag, "_byte"}, 32'(rx_q[i]), 32'(tx_q[i]));
        end
        rx_q.delete();
        tx_q.delete();
    endtask

    // Accepted bytes, as seen on the input handshake.
    always @(negedge clock) begin
        if (!reset && data_valid && data_ready) begin
            tx_q.push_back(data_in);
        end
    end

    // Line decoder: a frame opens on a low level, spans 10*CPB samples, and every bit
    // period must hold one level for its whole width.
    always @(negedge clock) begin
        if (reset) begin
            mon_active = 1'b0;
            mon_n      = 0;
        end else if (!mon_active) begin
            if (serial_connection === 1'b0) begin
                mon_active = 1'b1;
                mon_s[0]   = 1'b0;
                mon_n      = 1;
            end
        end else begin
            mon_s[mon_n] = serial_connection;
            mon_n++;
            if (mon_n == FRAME) begin
                mon_werr = 0;
                for (int i = 0; i < 10; i++) begin
                    for (int j = 1; j < CPB; j++) begin
                        if (mon_s[i*CPB+j] !== mon_s[i*CPB]) mon_werr++;
                    end
                end
                for (int i = 0; i < 8; i++) begin
                    mon_byte[i] = mon_s[(i+1)*CPB];
                end
                check_eq("mon_bit_width", 32'(mon_werr), 32'd0);
                check_eq("mon_stop_bit", 32'(mon_s[9*CPB]), 32'd1);
                rx_q.push_back(mon_byte);
                mon_active = 1'b0;
                mon_n      = 0;
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int acc [6];
        int exp_off [6];
        logic [7:0] d;
        int n;
        int gap;

        exp_off = '{0, 1, 2, 3, 4, 42};

        // Reset state
        repeat (3) step(1'b1, 1'b0, 8'h00);
        check_eq("rst_line", 32'(serial_connection), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ready", 32'(data_ready), 32'd0);
        step(1'b0, 1'b0, 8'h00);
        check_eq("ready_after_release", 32'(data_ready), 32'd1);
        check_eq("line_after_release", 32'(serial_connection), 32'd1);

        // Single byte 0xA5: start bit from t+2, idle again at t+42
        step(1'b0, 1'b1, 8'hA5);
        check_eq("a5_accept", 32'(data_ready), 32'd1);
        step(1'b0, 1'b0, 8'h00);
        check_eq("a5_line_t1", 32'(serial_connection), 32'd1);
        check_eq("a5_busy_t1", 32'(busy), 32'd1);
        for (int k = 0; k < FRAME; k++) begin
            step(1'b0, 1'b0, 8'h00);
            check_eq("a5_line", 32'(serial_connection), 32'(frame_bit(8'hA5, k / CPB)));
        end
        step(1'b0, 1'b0, 8'h00);
        check_eq("a5_line_end", 32'(serial_connection), 32'd1);
        check_eq("a5_busy_end", 32'(busy), 32'd0);
        wait_idle("a5");
        compare_stream("a5");

        // Back-to-back 0x00 then 0xFF: contiguous 20-bit stretch
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'hFF);
        check_eq("b2b_accept", 32'(data_ready), 32'd1);
        for (int k = 0; k < 2 * FRAME; k++) begin
            step(1'b0, 1'b0, 8'h00);
            d = (k < FRAME) ? 8'h00 : 8'hFF;
            check_eq("b2b_line", 32'(serial_connection), 32'(frame_bit(d, (k % FRAME) / CPB)));
            if (k == 2 * FRAME - 1) check_eq("b2b_busy_last", 32'(busy), 32'd1);
        end
        step(1'b0, 1'b0, 8'h00);
        check_eq("b2b_line_end", 32'(serial_connection), 32'd1);
        check_eq("b2b_busy_end", 32'(busy), 32'd0);
        wait_idle("b2b");
        compare_stream("b2b");

        // Overflow: full FIFO blocks 0x06 until the cycle after frame 2 is popped
        for (int b = 0; b < 6; b++) begin
            n = 0;
            step(1'b0, 1'b1, 8'(b + 1));
            if (b == 5) check_eq("ovf_ready_low_when_full", 32'(data_ready), 32'd0);
            while (!data_ready && n < 200) begin
                step(1'b0, 1'b1, 8'(b + 1));
                n++;
            end
            check_eq("ovf_accepted", 32'(data_ready), 32'd1);
            acc[b] = nsteps;
        end
        for (int b = 0; b < 6; b++) begin
            check_eq("ovf_accept_offset", 32'(acc[b] - acc[0]), 32'(exp_off[b]));
        end
        step(1'b0, 1'b0, 8'h00);
        wait_idle("ovf");
        compare_stream("ovf");

        // Reset during data bit 3 of 0x3C, then a clean 0x81 frame
        step(1'b0, 1'b1, 8'h3C);
        for (int k = 1; k <= 18; k++) step(1'b0, 1'b0, 8'h00);
        check_eq("rmf_bit3", 32'(serial_connection), 32'(frame_bit(8'h3C, 4)));
        step(1'b1, 1'b0, 8'h00);
        check_eq("rmf_ready_in_reset", 32'(data_ready), 32'd0);
        step(1'b0, 1'b0, 8'h00);
        check_eq("rmf_line", 32'(serial_connection), 32'd1);
        check_eq("rmf_busy", 32'(busy), 32'd0);
        check_eq("rmf_ready", 32'(data_ready), 32'd1);
        tx_q.delete();
        rx_q.delete();
        step(1'b0, 1'b1, 8'h81);
        step(1'b0, 1'b0, 8'h00);
        for (int k = 0; k < FRAME; k++) begin
            step(1'b0, 1'b0, 8'h00);
            check_eq("rmf_81_line", 32'(serial_connection), 32'(frame_bit(8'h81, k / CPB)));
        end
        wait_idle("rmf");
        compare_stream("rmf");

        // Random stress: 500 bytes with random gaps; data wiggles while not valid
        for (int i = 0; i < 500; i++) begin
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 60)) : 0;
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 8'($urandom));
            d = 8'($urandom);
            n = 0;
            step(1'b0, 1'b1, d);
            while (!data_ready && n < 1000) begin
                step(1'b0, 1'b1, d);
                n++;
            end
            check_eq("stress_accepted", 32'(data_ready), 32'd1);
        end
        step(1'b0, 1'b0, 8'h00);
        wait_idle("stress");
        compare_stream("stress");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
